// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, port identifiers
// and the latched request record.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_e;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } arb_port_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bytemask;
  } mem_req_struct;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner select between the CPU and DMA ports.
// ARB_ROUND_ROBIN_EN: ties alternate via last_grant; otherwise the CPU always wins ties.
module arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic      cpu_req,
  input  logic      dma_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  arb_port_e last_grant,
`endif
  output logic      valid,
  output arb_port_e winner
);

  always_comb begin
    valid  = cpu_req | dma_req;
    winner = PORT_CPU;
`ifdef ARB_ROUND_ROBIN_EN
    if (cpu_req && dma_req) begin
      winner = (last_grant == PORT_CPU) ? PORT_DMA : PORT_CPU;
    end else if (dma_req) begin
      winner = PORT_DMA;
    end
`else
    if (!cpu_req && dma_req) begin
      winner = PORT_DMA;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter (CPU / DMA) in front of a fixed-latency single-port data memory.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternating tie-break instead of CPU priority).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [3:0]  cpu_bytemask_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_ack_o,
  output logic        cpu_stall_o,
  input  logic        dma_req_i,
  input  logic        dma_we_i,
  input  logic [31:0] dma_addr_i,
  input  logic [31:0] dma_wdata_i,
  input  logic [3:0]  dma_bytemask_i,
  output logic [31:0] dma_rdata_o,
  output logic        dma_ack_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_bytemask_o,
  input  logic [31:0] mem_rdata_i
);

  if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT must be in 1..7");
  end

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

  arb_state_e    state, next_state;
  logic [2:0]    cnt;
  arb_port_e     grant_port;
  mem_req_struct req_q;
  mem_req_struct cpu_fields, dma_fields;
  logic [31:0]   cpu_rdata_q, dma_rdata_q;
  logic          pick_valid;
  arb_port_e     pick_port;

`ifdef ARB_ROUND_ROBIN_EN
  arb_port_e     last_grant;
`endif

  assign cpu_fields = '{we: cpu_we_i, addr: cpu_addr_i, wdata: cpu_wdata_i, bytemask: cpu_bytemask_i};
  assign dma_fields = '{we: dma_we_i, addr: dma_addr_i, wdata: dma_wdata_i, bytemask: dma_bytemask_i};

  arb_pick u_pick (
    .cpu_req    (cpu_req_i),
    .dma_req    (dma_req_i),
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant (last_grant),
`endif
    .valid      (pick_valid),
    .winner     (pick_port)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    mem_req_o  = 1'b0;
    cpu_ack_o  = 1'b0;
    dma_ack_o  = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          next_state = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        mem_req_o  = 1'b1;
        next_state = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (cnt == '0) begin
          next_state = ARB_RESP;
        end
      end
      ARB_RESP: begin
        cpu_ack_o  = (grant_port == PORT_CPU);
        dma_ack_o  = (grant_port == PORT_DMA);
        next_state = ARB_IDLE;
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  // Request fields are frozen at grant so a requester that misbehaves after
  // acceptance cannot disturb the access in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt         <= '0;
      grant_port  <= PORT_CPU;
      req_q       <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant  <= PORT_DMA;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            grant_port <= pick_port;
            req_q      <= (pick_port == PORT_CPU) ? cpu_fields : dma_fields;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= pick_port;
`endif
          end
        end
        ARB_ISSUE: cnt <= LAT_LOAD;
        ARB_WAIT: begin
          if (cnt == '0) begin
            if (!req_q.we) begin
              if (grant_port == PORT_CPU) cpu_rdata_q <= mem_rdata_i;
              else                        dma_rdata_q <= mem_rdata_i;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_we_o       = req_q.we;
  assign mem_addr_o     = req_q.addr;
  assign mem_wdata_o    = req_q.wdata;
  assign mem_bytemask_o = req_q.bytemask;
  assign cpu_rdata_o    = cpu_rdata_q;
  assign dma_rdata_o    = dma_rdata_q;
  assign cpu_stall_o    = cpu_req_i & ~cpu_ack_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with MEM_LAT=2 and a
// fixed-latency memory model returning address-derived data.
module tb_mem_port_arbiter;

  localparam int unsigned MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [3:0]  cpu_bytemask, dma_bytemask;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        cpu_ack, cpu_stall, dma_ack;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_bytemask;
  logic [31:0] mem_rdata = 32'hA5A5_A5A5;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cpu_req_i      (cpu_req),
    .cpu_we_i       (cpu_we),
    .cpu_addr_i     (cpu_addr),
    .cpu_wdata_i    (cpu_wdata),
    .cpu_bytemask_i (cpu_bytemask),
    .cpu_rdata_o    (cpu_rdata),
    .cpu_ack_o      (cpu_ack),
    .cpu_stall_o    (cpu_stall),
    .dma_req_i      (dma_req),
    .dma_we_i       (dma_we),
    .dma_addr_i     (dma_addr),
    .dma_wdata_i    (dma_wdata),
    .dma_bytemask_i (dma_bytemask),
    .dma_rdata_o    (dma_rdata),
    .dma_ack_o      (dma_ack),
    .mem_req_o      (mem_req),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_bytemask_o (mem_bytemask),
    .mem_rdata_i    (mem_rdata)
  );

  // Memory model: data valid only in the cycle exactly two cycles after the strobe.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_0000);
  endfunction

  logic        v1 = 1'b0;
  logic [31:0] d1 = '0;
  always @(posedge clk) begin
    v1        <= mem_req;
    d1        <= mem_fn(mem_addr);
    mem_rdata <= v1 ? d1 : 32'hA5A5_A5A5;
  end

  task automatic clear_reqs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_bytemask = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; dma_bytemask = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_ack(input bit on_dma, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if ((on_dma ? dma_ack : cpu_ack) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear_reqs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (cpu_ack !== 1'b0) begin failures++; $display("FAIL reset_cpu_ack got=%h exp=0", cpu_ack); end
    checks++; if (dma_ack !== 1'b0) begin failures++; $display("FAIL reset_dma_ack got=%h exp=0", dma_ack); end
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_cpu_stall got=%h exp=0", cpu_stall); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%h exp=0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%h exp=0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    checks++; if (mem_bytemask !== 4'h0) begin failures++; $display("FAIL reset_mem_bytemask got=%h exp=0", mem_bytemask); end
    checks++; if (cpu_rdata !== 32'h0) begin failures++; $display("FAIL reset_cpu_rdata got=%h exp=0", cpu_rdata); end
    checks++; if (dma_rdata !== 32'h0) begin failures++; $display("FAIL reset_dma_rdata got=%h exp=0", dma_rdata); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cpu_read();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0100;
    #1;
    for (int k = 0; k <= 5; k++) begin
      checks++; if (cpu_stall !== (k < 4)) begin failures++; $display("FAIL cpu_read_stall k=%0d got=%h exp=%h", k, cpu_stall, (k < 4)); end
      checks++; if (cpu_ack !== (k == 4)) begin failures++; $display("FAIL cpu_read_ack k=%0d got=%h exp=%h", k, cpu_ack, (k == 4)); end
      checks++; if (mem_req !== (k == 1)) begin failures++; $display("FAIL cpu_read_mem_req k=%0d got=%h exp=%h", k, mem_req, (k == 1)); end
      if (k == 1) begin
        checks++; if (mem_addr !== 32'h0000_0100) begin failures++; $display("FAIL cpu_read_mem_addr got=%h exp=00000100", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL cpu_read_mem_we got=%h exp=0", mem_we); end
      end
      if (k >= 4) begin
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL cpu_read_rdata k=%0d got=%h exp=deadbeef", k, cpu_rdata); end
      end
      if (k == 4) cpu_req = 0;
      @(negedge clk); #1;
    end
  endtask

  task automatic test_dma_write();
    dma_req = 1; dma_we = 1; dma_addr = 32'h0000_0020; dma_wdata = 32'h1234_5678; dma_bytemask = 4'h3;
    #1;
    for (int k = 0; k <= 5; k++) begin
      checks++; if (dma_ack !== (k == 4)) begin failures++; $display("FAIL dma_write_ack k=%0d got=%h exp=%h", k, dma_ack, (k == 4)); end
      checks++; if (mem_req !== (k == 1)) begin failures++; $display("FAIL dma_write_mem_req k=%0d got=%h exp=%h", k, mem_req, (k == 1)); end
      if (k == 1) begin
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL dma_write_mem_we got=%h exp=1", mem_we); end
        checks++; if (mem_addr !== 32'h0000_0020) begin failures++; $display("FAIL dma_write_mem_addr got=%h exp=00000020", mem_addr); end
        checks++; if (mem_wdata !== 32'h1234_5678) begin failures++; $display("FAIL dma_write_mem_wdata got=%h exp=12345678", mem_wdata); end
        checks++; if (mem_bytemask !== 4'h3) begin failures++; $display("FAIL dma_write_mem_bytemask got=%h exp=3", mem_bytemask); end
      end
      if (k >= 4) begin
        checks++; if (dma_rdata !== 32'h0) begin failures++; $display("FAIL dma_write_rdata k=%0d got=%h exp=0", k, dma_rdata); end
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL dma_write_cpu_rdata k=%0d got=%h exp=deadbeef", k, cpu_rdata); end
      end
      if (k == 4) begin dma_req = 0; dma_we = 0; end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int t1, t2;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0100;
    wait_ack(1'b0, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL b2b_first_ack_timeout got=%h exp=1", ok); end
    t1 = cyc;
    cpu_addr = 32'h0000_0104;
    @(negedge clk); #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL b2b_accept_mem_req got=%h exp=0", mem_req); end
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL b2b_accept_stall got=%h exp=1", cpu_stall); end
    @(negedge clk); #1;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL b2b_issue_mem_req got=%h exp=1", mem_req); end
    checks++; if (mem_addr !== 32'h0000_0104) begin failures++; $display("FAIL b2b_issue_addr got=%h exp=00000104", mem_addr); end
    wait_ack(1'b0, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL b2b_second_ack_timeout got=%h exp=1", ok); end
    t2 = cyc;
    checks++; if (t2 - t1 !== 5) begin failures++; $display("FAIL b2b_ack_spacing got=%0d exp=5", t2 - t1); end
    checks++; if (cpu_rdata !== 32'hC0DE_0104) begin failures++; $display("FAIL b2b_rdata got=%h exp=c0de0104", cpu_rdata); end
    cpu_req = 0;
    @(negedge clk);
  endtask

  task automatic test_tie();
    int  last_t;
    bit  dma_seen;
    bit  got;
    bit  port;
    bit  exp_port;
    clear_reqs();
    pulse_reset();
    cpu_req = 1; cpu_addr = 32'h0000_0200;
    dma_req = 1; dma_addr = 32'h0000_0300;
    dma_seen = 0;
    last_t = 0;
    for (int i = 0; i < 4; i++) begin
      got = 0;
      port = 0;
      for (int j = 0; j < 20; j++) begin
        @(negedge clk); #1;
        if (dma_ack === 1'b1) dma_seen = 1;
        if (cpu_ack === 1'b1 || dma_ack === 1'b1) begin
          got = 1;
          port = (dma_ack === 1'b1);
          break;
        end
      end
`ifdef ARB_ROUND_ROBIN_EN
      exp_port = (i % 2 == 1);
`else
      exp_port = 1'b0;
`endif
      checks++; if (got !== 1'b1) begin failures++; $display("FAIL tie_ack_timeout i=%0d got=%h exp=1", i, got); end
      checks++; if (port !== exp_port) begin failures++; $display("FAIL tie_grant_order i=%0d got=%h exp=%h", i, port, exp_port); end
      checks++; if ((cpu_ack & dma_ack) !== 1'b0) begin failures++; $display("FAIL tie_double_ack i=%0d got=%h exp=0", i, cpu_ack & dma_ack); end
      if (i > 0) begin
        checks++; if (cyc - last_t !== 5) begin failures++; $display("FAIL tie_ack_spacing i=%0d got=%0d exp=5", i, cyc - last_t); end
      end
      if (port) begin
        checks++; if (dma_rdata !== 32'hC0DE_0300) begin failures++; $display("FAIL tie_dma_rdata i=%0d got=%h exp=c0de0300", i, dma_rdata); end
      end else begin
        checks++; if (cpu_rdata !== 32'hC0DE_0200) begin failures++; $display("FAIL tie_cpu_rdata i=%0d got=%h exp=c0de0200", i, cpu_rdata); end
      end
      last_t = cyc;
    end
`ifndef ARB_ROUND_ROBIN_EN
    checks++; if (dma_seen !== 1'b0) begin failures++; $display("FAIL tie_dma_starved got=%h exp=0", dma_seen); end
`endif
    clear_reqs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    dma_req = 1; dma_we = 0; dma_addr = 32'h0000_0040;
    @(negedge clk); #1;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rmid_issue got=%h exp=1", mem_req); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rmid_mem_req got=%h exp=0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rmid_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (dma_ack !== 1'b0) begin failures++; $display("FAIL rmid_dma_ack got=%h exp=0", dma_ack); end
    checks++; if (cpu_rdata !== 32'h0) begin failures++; $display("FAIL rmid_cpu_rdata got=%h exp=0", cpu_rdata); end
    checks++; if (dma_rdata !== 32'h0) begin failures++; $display("FAIL rmid_dma_rdata got=%h exp=0", dma_rdata); end
    @(negedge clk); #1;
    checks++; if (dma_ack !== 1'b0) begin failures++; $display("FAIL rmid_held_ack got=%h exp=0", dma_ack); end
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      checks++; if (dma_ack !== (k == 4)) begin failures++; $display("FAIL rmid_post_ack k=%0d got=%h exp=%h", k, dma_ack, (k == 4)); end
      checks++; if (mem_req !== (k == 1)) begin failures++; $display("FAIL rmid_post_mem_req k=%0d got=%h exp=%h", k, mem_req, (k == 1)); end
      if (k == 1) begin
        checks++; if (mem_addr !== 32'h0000_0040) begin failures++; $display("FAIL rmid_post_addr got=%h exp=00000040", mem_addr); end
      end
      if (k == 4) begin
        checks++; if (dma_rdata !== 32'hC0DE_0040) begin failures++; $display("FAIL rmid_post_rdata got=%h exp=c0de0040", dma_rdata); end
        dma_req = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_drop();
    int acks;
    acks = 0;
    dma_req = 1; dma_we = 0; dma_addr = 32'h0000_0060;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk); #1;
      if (dma_ack === 1'b1) acks++;
      checks++; if (dma_ack !== (k == 4)) begin failures++; $display("FAIL drop_ack k=%0d got=%h exp=%h", k, dma_ack, (k == 4)); end
      checks++; if (mem_req !== (k == 1)) begin failures++; $display("FAIL drop_mem_req k=%0d got=%h exp=%h", k, mem_req, (k == 1)); end
      if (k == 4) begin
        checks++; if (dma_rdata !== 32'hC0DE_0060) begin failures++; $display("FAIL drop_rdata got=%h exp=c0de0060", dma_rdata); end
      end
      if (k == 2) dma_req = 0;
    end
    checks++; if (acks !== 1) begin failures++; $display("FAIL drop_ack_count got=%0d exp=1", acks); end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_back_to_back();
    test_tie();
    test_reset_mid();
    test_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter sharing one single-port data memory between the pipeline MEM stage (CPU port) and a DMA/loader port (DMA port). Sequences each access through issue, fixed-latency wait and response phases, and drives a stall to the pipeline while a CPU access is outstanding. Sits between the LSU memory interface and the physical data memory.

## Interface
- MEM_LAT, 2: cycles from the `mem_req_o` cycle to valid `mem_rdata_i`; legal range 1..7.
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- cpu_req_i  in  1  CPU request; held, with fields stable, until the `cpu_ack_o` cycle.
- cpu_we_i / cpu_addr_i / cpu_wdata_i / cpu_bytemask_i  in  1/32/32/4  CPU write enable, address, store data, byte mask.
- cpu_rdata_o  out  32  CPU read data; valid in the ack cycle and held until the next CPU ack.
- cpu_ack_o  out  1  one-cycle completion pulse.
- cpu_stall_o  out  1  `cpu_req_i & ~cpu_ack_o`; freezes the pipeline.
- dma_req_i / dma_we_i / dma_addr_i / dma_wdata_i / dma_bytemask_i  in  1/1/32/32/4  DMA request fields; same rules as CPU.
- dma_rdata_o  out  32; dma_ack_o  out  1  same rules as CPU.
- mem_req_o  out  1  one-cycle memory strobe.
- mem_we_o / mem_addr_o / mem_wdata_o / mem_bytemask_o  out  1/32/32/4  latched fields of the granted request.
- mem_rdata_i  in  32  memory read data; valid exactly MEM_LAT cycles after the `mem_req_o` cycle.

## Operation
- FSM states ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP.
- ARB_IDLE: if any request is pending, the picker selects a winner. Its fields are latched, `grant_port` is recorded and the FSM goes to ARB_ISSUE. With no request pending, the FSM stays in ARB_IDLE.
- ARB_ISSUE: `mem_req_o`=1 with the latched fields. Counter loads MEM_LAT-1. Next state is ARB_WAIT.
- ARB_WAIT: the counter decrements each cycle. When the counter is 0, `mem_rdata_i` is captured into the granted port's rdata register and the FSM goes to ARB_RESP.
- ARB_RESP: the granted port's ack is 1. Requests are ignored in this cycle. Next state is ARB_IDLE.
- Writes follow the same sequence. For a write, the rdata register of the port is not updated.
- Fields are latched at grant. A requester that drops req mid-transaction (protocol violation) still gets its access executed and acked.
- mem_* field outputs hold their last value outside ARB_ISSUE.
- Counter is 3 bits wide. MEM_LAT outside 1..7 is an elaboration error.

## Timing
- Reset values: every output 0; FSM ARB_IDLE; counter 0; `last_grant`=DMA.
- Reset mid-transaction clears the state immediately. The in-flight memory response is discarded and no ack is issued.
- Request accepted in cycle N (ARB_IDLE, req high):
  - ARB_ISSUE in N+1.
  - Data captured in N+1+MEM_LAT.
  - Ack in N+2+MEM_LAT.
  - ARB_IDLE again in N+3+MEM_LAT.
- Latency from accept to ack is MEM_LAT+2 cycles. Minimum request period is MEM_LAT+3 cycles.
- A req still high in the cycle after its ack is treated as a new request.
- Simultaneous requests: resolved by the picker, see Configuration. The loser's stall (CPU) or wait (DMA) continues.
- `cpu_stall_o` is combinational from `cpu_req_i` and the registered ack. It is low in the ack cycle so the pipeline advances on that edge.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on simultaneous requests the port not in `last_grant` wins. `last_grant` updates at each grant. Reset value DMA, so the CPU wins the first tie.
- ARB_ROUND_ROBIN_EN undefined: the CPU always wins ties and `last_grant` is not implemented. The DMA port is served only in ARB_IDLE cycles with no CPU request.

## Structure
- StructPkg additions:
  - `arb_state_e` enum: ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP.
  - `mem_req_struct` typedef: we, addr[31:0], wdata[31:0], bytemask[3:0].
  - `arb_port_e` enum: PORT_CPU=0, PORT_DMA=1.
- Sub-module `arb_pick`: combinational winner select from `cpu_req`, `dma_req` and `last_grant`. Contains the ARB_ROUND_ROBIN_EN logic.

## Test plan
All scenarios use MEM_LAT=2.
- CPU read alone: CPU read request to addr 0x100 (memory returns 0xDEADBEEF).
  - `mem_req_o` is 1 in the cycle after acceptance, with `mem_addr_o`=0x100 and `mem_we_o`=0.
  - `cpu_ack_o` is 1 exactly 4 cycles after acceptance, with `cpu_rdata_o`=0xDEADBEEF.
  - `cpu_stall_o` is 1 for 4 cycles, then 0 in the ack cycle.
- DMA write alone: DMA write to addr 0x20, wdata 0x12345678, bytemask 0x3.
  - `mem_we_o`=1, `mem_wdata_o`=0x12345678 and `mem_bytemask_o`=0x3 in ARB_ISSUE.
  - `dma_ack_o` is 1 in cycle +4.
  - `dma_rdata_o` is unchanged.
- Simultaneous requests, held continuously for 4 transactions:
  - With ARB_ROUND_ROBIN_EN: grant order is CPU, DMA, CPU, DMA, with acks 5 cycles apart.
  - Without it: four consecutive CPU grants, and `dma_ack_o` stays 0.
- Back-to-back CPU: `cpu_req_i` kept high after an ack with a new address 0x104.
  - The second transaction is accepted in the cycle after the ack, and the second ack follows 5 cycles after the first.
- Reset mid-transaction: `rst_ni` low for 1 cycle while in ARB_WAIT.
  - All outputs 0 immediately; no ack.
  - After release, a pending request is accepted normally.
- Requester drops `dma_req_i` during ARB_WAIT: `dma_ack_o` still pulses once, and the FSM returns to ARB_IDLE.
